// File: rtl/lfsr_word_arb.sv
// lfsr_word_arb: round-robin sequencer that shares one lfsr8 PRBS generator among NREQ requesters
module lfsr_word_arb #(
    parameter int         NREQ      = 4,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] SEED_INIT = 8'h01
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic [NREQ-1:0]  Req_SI,
    output logic [NREQ-1:0]  Gnt_SO,
    output logic             Valid_SO,
    output logic [WIDTH-1:0] Word_DO,
    output logic             Busy_SO,
    input  logic             SeedWr_SI,
    input  logic [7:0]       Seed_DI,
    output logic             LfsrLoad_SO,
    output logic             LfsrEna_SO,
    output logic [7:0]       LfsrSeed_DO,
    input  logic             LfsrBit_DI
);
    localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {SEED, IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [7:0]       seed_q, seed_d;
    logic             pend_q, pend_d;
    logic [LW-1:0]    last_q, last_d, win, idx;
    logic             found;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, word_q, word_d;
    logic             last_bit;

    assign last_bit = cnt_q == CW'(WIDTH - 1);

    // round-robin search starting just after the previous winner
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(last_q) + k) % NREQ);
            if (!found && Req_SI[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // next-state logic; seed writes land in any state and re-arm a pending reload
    always_comb begin
        state_d = state_q;
        seed_d  = SeedWr_SI ? (Seed_DI == 8'h00 ? SEED_INIT : Seed_DI) : seed_q;
        pend_d  = SeedWr_SI || (pend_q && state_q != SEED);
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        word_d  = word_q;
        case (state_q)
            SEED: state_d = IDLE;
            IDLE: begin
                if (pend_q) begin
                    state_d = SEED;
                end else if (found) begin
                    state_d = SHIFT;
                    gnt_d   = NREQ'(1) << win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sh_d[cnt_q] = LfsrBit_DI;
                cnt_d       = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    word_d  = sh_d;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // state and datapath registers; reset aborts any transaction and forces a reload
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= SEED;
            seed_q  <= SEED_INIT;
            pend_q  <= 1'b0;
            last_q  <= LW'(NREQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        Gnt_SO      = gnt_q;
        Valid_SO    = state_q == DONE;
        Word_DO     = word_q;
        Busy_SO     = state_q != IDLE;
        LfsrLoad_SO = state_q == SEED;
        LfsrEna_SO  = state_q == SHIFT;
        LfsrSeed_DO = seed_q;
    end
endmodule

// File: tb/tb_lfsr_word_arb.sv
// tb_lfsr_word_arb: directed and randomized checks of lfsr_word_arb against a transaction-level model
module tb_lfsr_word_arb;
    localparam int         N    = 4;
    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'h01;

    logic          clk = 1'b0, rst = 1'b1;
    logic [N-1:0]  req8 = '0, req12 = '0, gnt8, gnt12;
    logic          seed_wr = 1'b0;
    logic [7:0]    seed_di = 8'h00;
    logic          v8, v12, busy8, busy12, ld8, ld12, en8, en12;
    logic [7:0]    word8, sd8, sd12;
    logic [11:0]   word12;
    logic [7:0]    g8 = 8'h00, g12 = 8'h00;
    int            n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    lfsr_word_arb #(.NREQ(N), .WIDTH(8), .SEED_INIT(INIT)) u8 (
        .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req8), .Gnt_SO(gnt8), .Valid_SO(v8),
        .Word_DO(word8), .Busy_SO(busy8), .SeedWr_SI(seed_wr), .Seed_DI(seed_di),
        .LfsrLoad_SO(ld8), .LfsrEna_SO(en8), .LfsrSeed_DO(sd8), .LfsrBit_DI(g8[0])
    );

    lfsr_word_arb #(.NREQ(N), .WIDTH(12), .SEED_INIT(INIT)) u12 (
        .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req12), .Gnt_SO(gnt12), .Valid_SO(v12),
        .Word_DO(word12), .Busy_SO(busy12), .SeedWr_SI(1'b0), .Seed_DI(8'h00),
        .LfsrLoad_SO(ld12), .LfsrEna_SO(en12), .LfsrSeed_DO(sd12), .LfsrBit_DI(g12[0])
    );

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    function automatic logic [31:0] prbs(input logic [7:0] s, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) begin
            w[i] = s[0];
            s    = step(s);
        end
        return w;
    endfunction

    function automatic logic [7:0] adv(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) s = step(s);
        return s;
    endfunction

    // the two lfsr8 generators driven by each sequencer
    always @(posedge clk) begin
        if (ld8) g8 <= sd8;
        else if (en8) g8 <= step(g8);
        if (ld12) g12 <= sd12;
        else if (en12) g12 <= step(g12);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model of the 8-bit instance: a load flag, the owner of the current word and its age in cycles
    bit         m_ok = 1'b0, m_load, m_pend;
    logic [7:0] m_seed, m_gen, m_word, m_tx;
    int         m_last, m_owner, m_age;

    task automatic model_step();
        int idx;
        if (rst) begin
            m_ok = 1'b1; m_load = 1'b1; m_seed = INIT; m_pend = 1'b0;
            m_last = N - 1; m_owner = -1; m_age = 0; m_word = 8'h00;
        end else if (m_ok) begin
            if (m_load) begin
                m_gen  = m_seed;
                m_load = 1'b0;
                m_pend = 1'b0;
            end else if (m_owner >= 0) begin
                if (m_age == W + 1) begin
                    m_owner = -1;
                    m_age   = 0;
                end else begin
                    m_age++;
                    if (m_age == W + 1) m_word = m_tx;
                end
            end else if (m_pend) begin
                m_load = 1'b1;
            end else if (req8 != '0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (m_owner < 0 && req8[idx[1:0]]) m_owner = idx;
                end
                m_last = m_owner;
                m_age  = 1;
                m_tx   = 8'(prbs(m_gen, W));
                m_gen  = adv(m_gen, W);
            end
            if (seed_wr) begin
                m_seed = seed_di == 8'h00 ? INIT : seed_di;
                m_pend = 1'b1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_ok) begin
            check("gnt",   32'(gnt8),  m_owner >= 0 ? (32'd1 << m_owner) : 32'd0);
            check("valid", 32'(v8),    32'(m_owner >= 0 && m_age == W + 1));
            check("ena",   32'(en8),   32'(m_owner >= 0 && m_age <= W));
            check("load",  32'(ld8),   32'(m_load));
            check("busy",  32'(busy8), 32'(m_load || m_owner >= 0));
            check("seed",  32'(sd8),   32'(m_seed));
            check("word",  32'(word8), 32'(m_word));
        end
    end

    task automatic wait_valid(input bit wide, output logic [31:0] word, output logic [3:0] gnt, output int lat);
        int rise = -1;
        word = '0; gnt = '0; lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rise < 0 && (wide ? gnt12 : gnt8) != '0) rise = c;
            if (wide ? v12 : v8) begin
                word = wide ? 32'(word12) : 32'(word8);
                gnt  = wide ? gnt12 : gnt8;
                lat  = c - rise;
                return;
            end
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sig(input int which, input string name);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (which == 0 ? en8 : which == 1 ? en12 : ld8) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  g;
        int          lat;
        logic [3:0]  rr [5];
        rr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req12 = 4'h1;
        wait_sig(1, "ena12_timeout");
        repeat (4) @(negedge clk);
        req12 = 4'h0;
        wait_valid(1'b1, w, g, lat);
        check("w12_word", w, 32'h101);
        check("w12_gnt", 32'(g), 32'h1);
        req8 = 4'h1;
        wait_valid(1'b0, w, g, lat);
        check("word_a", w, 32'h01);
        check("lat_a", 32'(lat), 32'd8);
        wait_valid(1'b0, w, g, lat);
        check("word_b", w, 32'h71);
        check("lat_b", 32'(lat), 32'd8);
        wait_valid(1'b0, w, g, lat);
        check("word_c", w, 32'hA4);
        check("lat_c", 32'(lat), 32'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req8 = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_valid(1'b0, w, g, lat);
            check("rr_gnt", 32'(g), 32'(rr[i]));
        end
        req8 = 4'h1;
        wait_sig(0, "ena8_timeout");
        repeat (3) @(negedge clk);
        seed_wr = 1'b1;
        seed_di = 8'h71;
        @(negedge clk);
        seed_wr = 1'b0;
        wait_valid(1'b0, w, g, lat);
        wait_valid(1'b0, w, g, lat);
        check("reseed_word", w, 32'h71);
        req8 = 4'h0;
        repeat (3) @(negedge clk);
        seed_wr = 1'b1;
        seed_di = 8'h00;
        @(negedge clk);
        seed_wr = 1'b0;
        wait_sig(2, "load_timeout");
        check("zero_seed", 32'(sd8), 32'h01);
        req8 = 4'h1;
        wait_valid(1'b0, w, g, lat);
        check("zero_word", w, 32'h01);
        req8 = 4'h2;
        wait_sig(0, "ena8_timeout");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_gnt", 32'(gnt8), 32'h0);
        check("abort_valid", 32'(v8), 32'h0);
        check("abort_load", 32'(ld8), 32'h1);
        rst = 1'b0;
        req8 = 4'hF;
        wait_valid(1'b0, w, g, lat);
        check("abort_next_gnt", 32'(g), 32'h1);
        check("abort_next_word", w, 32'h01);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req8 = 4'($urandom);
            seed_wr = ($urandom_range(0, 19) == 0);
            seed_di = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        seed_wr = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
